pipe_ctrl: RTL and testbench

Pipeline sequencing controller for the 16-bit, 8-register pipelined core. It decides each cycle whether every pipeline register advances, holds, or is cleared. The cases are a load-use hazard, a taken branch resolved in EX, and a multi-cycle data-memory access with timeout. It sits beside the datapath and drives the enable/bubble/flush inputs of PC, IF/ID, ID/EX, EX/MEM and MEM/WB; the ID/EX register gains `idex_en` and `idex_bubble` inputs for this.

---
 rtl/pipe_ctrl_pkg.sv | 15 +
 rtl/pipe_ctrl_hazard_detect.sv | 18 +
 rtl/pipe_ctrl.sv | 130 +++++++++++++
 tb/tb_pipe_ctrl.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and constants for the pipeline sequencing controller
package pipe_ctrl_pkg;

  localparam int REG_W        = 3;
  localparam int MAX_WAIT_DEF = 15;
  localparam int WAIT_W       = 8;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERR      = 2'd2,
    ST_UNUSED   = 2'd3
  } pipe_state_e;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// rtl/pipe_ctrl_hazard_detect.sv - load-use comparator between the ID instruction and a load in ID/EX
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_uses_rs2,
  input  logic             ex_mread,
  input  logic             ex_rwrite,
  input  logic [REG_W-1:0] ex_wreg,
  output logic             lu
);

  // Every register index participates; r0 is an ordinary register in this core.
  assign lu = ex_mread & ex_rwrite &
              ((ex_wreg == id_rs1) | (id_uses_rs2 & (ex_wreg == id_rs2)));

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - per-cycle advance/hold/clear decisions for PC and the four pipeline registers
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEF,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_uses_rs2,
  input  logic             ex_mread,
  input  logic             ex_rwrite,
  input  logic [REG_W-1:0] ex_wreg,
  input  logic             ex_br_taken,
  input  logic             mem_req,
  input  logic             mem_ack,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic [1:0]       state,
  output logic             err,
  output logic [CNT_W-1:0] stall_cycles
);

  pipe_state_e       state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  stall_q;
  logic              lu;
  logic              run_rules;

  hazard_detect u_hazard_detect (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs2 (id_uses_rs2),
    .ex_mread    (ex_mread),
    .ex_rwrite   (ex_rwrite),
    .ex_wreg     (ex_wreg),
    .lu          (lu)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      wait_q  <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (!pc_en && (stall_q != {CNT_W{1'b1}}))
        stall_q <= stall_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    run_rules = 1'b0;

    unique case (state_q)
      ST_RUN: begin
        if (mem_req && !mem_ack) begin
          state_d = ST_MEM_WAIT;
          wait_d  = WAIT_W'(1);
        end else begin
          run_rules = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        // An ack in the timeout cycle still completes the access.
        if (mem_ack) begin
          run_rules = 1'b1;
          state_d   = ST_RUN;
          wait_d    = '0;
        end else if (wait_q == WAIT_W'(MAX_WAIT)) begin
          state_d = ST_ERR;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      ST_ERR: begin
        state_d = ST_ERR;
      end
      default: begin
        state_d = ST_RUN;
        wait_d  = '0;
      end
    endcase
  end

  always_comb begin
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    idex_en     = 1'b0;
    exmem_en    = 1'b0;
    memwb_en    = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;

    if (rst) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (run_rules) begin
      pc_en    = 1'b1;
      ifid_en  = 1'b1;
      idex_en  = 1'b1;
      exmem_en = 1'b1;
      memwb_en = 1'b1;
      // A taken branch squashes the ID instruction, so its load-use hazard is moot.
      if (ex_br_taken) begin
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
      end else if (lu) begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_bubble = 1'b1;
      end
    end
  end

  assign state        = state_q;
  assign err          = (state_q == ST_ERR) && !rst;
  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - directed and random checks of pipe_ctrl against a behavioural model
module tb_pipe_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] id_rs1, id_rs2, ex_wreg;
  logic       id_uses_rs2, ex_mread, ex_rwrite, ex_br_taken, mem_req, mem_ack;

  logic       pc_en_a, ifid_en_a, idex_en_a, exmem_en_a, memwb_en_a, ifid_flush_a, idex_bubble_a, err_a;
  logic       pc_en_b, ifid_en_b, idex_en_b, exmem_en_b, memwb_en_b, ifid_flush_b, idex_bubble_b, err_b;
  logic [1:0] state_a, state_b;
  logic [15:0] stall_a;
  logic [3:0]  stall_b;
  logic [7:0]  ctl_a, ctl_b;

  int n_checks = 0;
  int n_fails  = 0;

  // Model: mode 0 = running, 1 = waiting on memory, 2 = dead after timeout.
  int m_mode[2];
  int m_waited[2];
  int m_stall[2];
  int maxw[2] = '{15, 3};
  int satv[2] = '{65535, 15};

  always #5 clk = ~clk;

  pipe_ctrl u_dut_a (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
    .ex_mread(ex_mread), .ex_rwrite(ex_rwrite), .ex_wreg(ex_wreg), .ex_br_taken(ex_br_taken),
    .mem_req(mem_req), .mem_ack(mem_ack), .pc_en(pc_en_a), .ifid_en(ifid_en_a),
    .idex_en(idex_en_a), .exmem_en(exmem_en_a), .memwb_en(memwb_en_a),
    .ifid_flush(ifid_flush_a), .idex_bubble(idex_bubble_a), .state(state_a),
    .err(err_a), .stall_cycles(stall_a)
  );

  pipe_ctrl #(.MAX_WAIT(3), .CNT_W(4)) u_dut_b (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
    .ex_mread(ex_mread), .ex_rwrite(ex_rwrite), .ex_wreg(ex_wreg), .ex_br_taken(ex_br_taken),
    .mem_req(mem_req), .mem_ack(mem_ack), .pc_en(pc_en_b), .ifid_en(ifid_en_b),
    .idex_en(idex_en_b), .exmem_en(exmem_en_b), .memwb_en(memwb_en_b),
    .ifid_flush(ifid_flush_b), .idex_bubble(idex_bubble_b), .state(state_b),
    .err(err_b), .stall_cycles(stall_b)
  );

  assign ctl_a = {pc_en_a, ifid_en_a, idex_en_a, exmem_en_a, memwb_en_a, ifid_flush_a, idex_bubble_a, err_a};
  assign ctl_b = {pc_en_b, ifid_en_b, idex_en_b, exmem_en_b, memwb_en_b, ifid_flush_b, idex_bubble_b, err_b};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected {pc,ifid,idex,exmem,memwb,flush,bubble,err} from the current inputs.
  function automatic logic [7:0] exp_ctl(input int d);
    bit lu_m, frozen;
    lu_m = ex_mread && ex_rwrite && (ex_wreg == id_rs1 || (id_uses_rs2 && ex_wreg == id_rs2));
    if (rst) return 8'b00000_1_1_0;
    if (m_mode[d] == 2) return 8'b00000_0_0_1;
    frozen = (m_mode[d] == 1) ? !mem_ack : (mem_req && !mem_ack);
    if (frozen) return 8'b00000_0_0_0;
    if (ex_br_taken) return 8'b11111_1_1_0;
    if (lu_m) return 8'b00111_0_1_0;
    return 8'b11111_0_0_0;
  endfunction

  task automatic model_step(input int d, input logic pc_exp);
    if (rst) begin
      m_mode[d] = 0; m_waited[d] = 0; m_stall[d] = 0;
    end else begin
      if (!pc_exp && m_stall[d] < satv[d]) m_stall[d]++;
      if (m_mode[d] == 0) begin
        if (mem_req && !mem_ack) begin m_mode[d] = 1; m_waited[d] = 1; end
      end else if (m_mode[d] == 1) begin
        if (mem_ack) m_mode[d] = 0;
        else if (m_waited[d] >= maxw[d]) m_mode[d] = 2;
        else m_waited[d]++;
      end
    end
  endtask

  task automatic cycle();
    logic [7:0] e;
    logic       pc_exp[2];
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      e = exp_ctl(d);
      pc_exp[d] = e[7];
      chk($sformatf("ctl_%0d", d), 32'(d == 0 ? ctl_a : ctl_b), 32'(e));
      chk($sformatf("state_%0d", d), 32'(d == 0 ? state_a : state_b), 32'(m_mode[d]));
      chk($sformatf("stall_%0d", d), (d == 0) ? 32'(stall_a) : 32'(stall_b), 32'(m_stall[d]));
    end
    for (int d = 0; d < 2; d++) model_step(d, pc_exp[d]);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_rs1 = 0; id_rs2 = 0; id_uses_rs2 = 0; ex_mread = 0; ex_rwrite = 0;
    ex_wreg = 0; ex_br_taken = 0; mem_req = 0; mem_ack = 0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    for (int d = 0; d < 2; d++) begin m_mode[d] = 0; m_waited[d] = 0; m_stall[d] = 0; end
    @(posedge clk); #1;
    cycle();
    rst = 1'b0;
    cycle();
    chk("reset_stall", 32'(stall_a), 32'd0);

    // Load-use on rs1: one stall cycle.
    ex_mread = 1; ex_rwrite = 1; ex_wreg = 3; id_rs1 = 3;
    cycle();
    id_rs1 = 0; ex_mread = 0;
    cycle();
    chk("lu_rs1_stall", 32'(stall_a), 32'd1);

    // rs2 only counts when the ID instruction reads it.
    ex_mread = 1; ex_wreg = 5; id_rs1 = 1; id_rs2 = 5; id_uses_rs2 = 0;
    cycle();
    chk("rs2_gated", 32'(stall_a), 32'd1);
    id_uses_rs2 = 1;
    cycle();
    chk("rs2_used", 32'(stall_a), 32'd2);

    // Taken branch overrides a concurrent load-use.
    ex_br_taken = 1;
    cycle();
    chk("br_lu_stall", 32'(stall_a), 32'd2);
    idle_inputs();

    // Memory access acked on the fifth cycle: four frozen cycles.
    mem_req = 1;
    for (int i = 0; i < 4; i++) cycle();
    mem_ack = 1;
    cycle();
    chk("memwait_state", 32'(state_a), 32'd0);
    chk("memwait_stall", 32'(stall_a), 32'd6);
    idle_inputs();
    rst = 1; cycle(); rst = 0;

    // Timeout on the MAX_WAIT=3 instance, then reset.
    mem_req = 1;
    for (int i = 0; i < 4; i++) cycle();
    chk("timeout_state", 32'(state_b), 32'd2);
    chk("timeout_err", 32'(err_b), 32'd1);
    mem_ack = 1;
    cycle();
    chk("err_sticky", 32'(err_b), 32'd1);
    idle_inputs();
    rst = 1; cycle(); rst = 0;
    chk("rst_state", 32'(state_b), 32'd0);
    chk("rst_err", 32'(err_b), 32'd0);
    chk("rst_stall", 32'(stall_b), 32'd0);

    // Saturation: 20 stalls on a 4-bit counter.
    ex_mread = 1; ex_rwrite = 1; ex_wreg = 2; id_rs1 = 2;
    for (int i = 0; i < 20; i++) cycle();
    chk("sat_b", 32'(stall_b), 32'd15);
    chk("sat_a", 32'(stall_a), 32'd20);
    idle_inputs();

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      rst         = ($urandom_range(0, 39) == 0);
      id_rs1      = 3'($urandom_range(0, 7));
      id_rs2      = 3'($urandom_range(0, 7));
      ex_wreg     = 3'($urandom_range(0, 7));
      id_uses_rs2 = 1'($urandom_range(0, 1));
      ex_mread    = 1'($urandom_range(0, 1));
      ex_rwrite   = 1'($urandom_range(0, 1));
      ex_br_taken = ($urandom_range(0, 5) == 0);
      mem_req     = ($urandom_range(0, 4) == 0);
      mem_ack     = ($urandom_range(0, 3) == 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
